// File: rtl/gcd_pkg.sv
// Shared types for the GCD engine: FSM states,
// mode encodings and the FSM-to-datapath action bundle.
package gcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic MODE_EUCLID = 1'b0;
  localparam logic MODE_STEIN  = 1'b1;

  typedef struct packed {
    logic load;
    logic sub_a;
    logic sub_b;
    logic shr_ab;
    logic shr_a;
    logic shr_b;
    logic fin;
  } act_t;

endpackage

// File: rtl/gcd_datapath.sv
// Operand registers, power-of-two exponent, iteration
// counter, comparator flags and the result register.
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  act_t             act,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             eq,
  output logic             gt,
  output logic             a_even,
  output logic             b_even,
  output logic [WIDTH-1:0] gcd_out,
  output logic [WIDTH-1:0] iters
);

  localparam int KW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] it_q, it_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic             step;

  assign eq     = (a_q == b_q);
  assign gt     = (a_q > b_q);
  assign a_even = ~a_q[0];
  assign b_even = ~b_q[0];

  assign step = act.sub_a | act.sub_b |
                act.shr_ab | act.shr_a |
                act.shr_b;

  always_comb begin
    a_d  = a_q;
    b_d  = b_q;
    k_d  = k_q;
    it_d = it_q;
    g_d  = g_q;
    unique case (1'b1)
      act.load: begin
        a_d  = a_in;
        b_d  = b_in;
        k_d  = '0;
        it_d = '0;
      end
      act.sub_a:  a_d = a_q - b_q;
      act.sub_b:  b_d = b_q - a_q;
      act.shr_ab: begin
        a_d = a_q >> 1;
        b_d = b_q >> 1;
        k_d = k_q + KW'(1);
      end
      act.shr_a:  a_d = a_q >> 1;
      act.shr_b:  b_d = b_q >> 1;
      act.fin:    g_d = a_q << k_q;
      default: ;
    endcase
    // count saturates rather than wrapping
    if (step && (it_q != '1))
      it_d = it_q + WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      k_q  <= '0;
      it_q <= '0;
      g_q  <= '0;
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      k_q  <= k_d;
      it_q <= it_d;
      g_q  <= g_d;
    end
  end

  assign gcd_out = g_q;
  assign iters   = it_q;

endmodule

// File: rtl/gcd_engine.sv
// GCD engine top: control FSM selecting one datapath
// action per cycle, Moore status outputs.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             mode,
  input  logic             abort,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             invalid,
  output logic [WIDTH-1:0] gcd_out,
  output logic [WIDTH-1:0] iters
);

  state_t state_q, state_d;
  logic   mode_q, mode_d;
  act_t   act;
  logic   eq, gt, a_even, b_even;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    act     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          mode_d = mode;
          if (a_in == '0 || b_in == '0) begin
            state_d = S_ERR;
          end else begin
            state_d  = S_CALC;
            act.load = 1'b1;
          end
        end
      end
      S_CALC: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (mode_q == MODE_EUCLID) begin
          if (eq) begin
            act.fin = 1'b1;
            state_d = S_DONE;
          end else if (gt) begin
            act.sub_a = 1'b1;
          end else begin
            act.sub_b = 1'b1;
          end
        end else begin
          if (a_even && b_even) begin
            act.shr_ab = 1'b1;
          end else if (a_even) begin
            act.shr_a = 1'b1;
          end else if (b_even) begin
            act.shr_b = 1'b1;
          end else if (eq) begin
            act.fin = 1'b1;
            state_d = S_DONE;
          end else if (gt) begin
            act.sub_a = 1'b1;
          end else begin
            act.sub_b = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_EUCLID;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  assign ready   = (state_q == S_IDLE);
  assign busy    = (state_q == S_CALC);
  assign done    = (state_q == S_DONE);
  assign invalid = (state_q == S_ERR);

  gcd_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk     (clk),
    .rst     (rst),
    .act     (act),
    .a_in    (a_in),
    .b_in    (b_in),
    .eq      (eq),
    .gt      (gt),
    .a_even  (a_even),
    .b_even  (b_even),
    .gcd_out (gcd_out),
    .iters   (iters)
  );

endmodule

// File: tb/tb_gcd_engine.sv
// Scenario bench for gcd_engine at WIDTH=16 and WIDTH=8;
// results are scored against an expected-value queue.
module tb_gcd_engine;

  typedef struct packed {
    logic [15:0] gcd;
    logic [15:0] iters;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        go16 = 0, mode16 = 0, abort16 = 0;
  logic [15:0] a16 = 0, b16 = 0;
  logic        ready16, busy16, done16, inv16;
  logic [15:0] gcd16, iters16;

  logic        go8 = 0, mode8 = 0, abort8 = 0;
  logic [7:0]  a8 = 0, b8 = 0;
  logic        ready8, busy8, done8, inv8;
  logic [7:0]  gcd8, iters8;

  int checks = 0;
  int errors = 0;
  exp_t q16[$];
  exp_t q8[$];

  always #5 clk = ~clk;

  gcd_engine #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .go(go16),
    .mode(mode16), .abort(abort16),
    .a_in(a16), .b_in(b16),
    .ready(ready16), .busy(busy16),
    .done(done16), .invalid(inv16),
    .gcd_out(gcd16), .iters(iters16)
  );

  gcd_engine #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .go(go8),
    .mode(mode8), .abort(abort8),
    .a_in(a8), .b_in(b8),
    .ready(ready8), .busy(busy8),
    .done(done8), .invalid(inv8),
    .gcd_out(gcd8), .iters(iters8)
  );

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done16) begin
        checks++;
        if (q16.size() == 0) begin
          errors++;
          $display("FAIL done16_unexpected gcd=%0d",
                   gcd16);
        end else begin
          e = q16.pop_front();
          if (gcd16 !== e.gcd ||
              iters16 !== e.iters) begin
            errors++;
            $display("FAIL result16 got %0d/%0d exp %0d/%0d",
                     gcd16, iters16, e.gcd, e.iters);
          end
        end
      end
      if (!rst && done8) begin
        checks++;
        if (q8.size() == 0) begin
          errors++;
          $display("FAIL done8_unexpected gcd=%0d",
                   gcd8);
        end else begin
          e = q8.pop_front();
          if ({8'd0, gcd8} !== e.gcd ||
              {8'd0, iters8} !== e.iters) begin
            errors++;
            $display("FAIL result8 got %0d/%0d exp %0d/%0d",
                     gcd8, iters8, e.gcd, e.iters);
          end
        end
      end
    end
  end

  task automatic wait_done16(output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done16 && c < 600);
    if (!done16) begin
      errors++;
      $display("FAIL done16_timeout after %0d", c);
    end
  endtask

  task automatic wait_done8(output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done8 && c < 600);
    if (!done8) begin
      errors++;
      $display("FAIL done8_timeout after %0d", c);
    end
  endtask

  task automatic run16(
    input logic [15:0] a, b,
    input logic        m,
    input logic [15:0] eg, ei,
    input int          lat,
    input string       nm
  );
    int c;
    exp_t e;
    @(negedge clk);
    a16 = a; b16 = b; mode16 = m; go16 = 1;
    e = '{gcd: eg, iters: ei};
    q16.push_back(e);
    @(posedge clk);
    #1 go16 = 0;
    wait_done16(c);
    checks++;
    if (c != lat) begin
      errors++;
      $display("FAIL %s_latency got %0d exp %0d",
               nm, c, lat);
    end
    @(negedge clk);
    checks++;
    if (ready16 !== 1'b1 || done16 !== 1'b0) begin
      errors++;
      $display("FAIL %s_ready got %b exp 1",
               nm, ready16);
    end
  endtask

  task automatic run8(
    input logic [7:0] a, b,
    input logic [15:0] eg, ei,
    input int          lat,
    input string       nm
  );
    int c;
    exp_t e;
    @(negedge clk);
    a8 = a; b8 = b; mode8 = 0; go8 = 1;
    e = '{gcd: eg, iters: ei};
    q8.push_back(e);
    @(posedge clk);
    #1 go8 = 0;
    wait_done8(c);
    checks++;
    if (c != lat) begin
      errors++;
      $display("FAIL %s_latency got %0d exp %0d",
               nm, c, lat);
    end
    @(negedge clk);
    checks++;
    if (ready8 !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready got %b exp 1",
               nm, ready8);
    end
  endtask

  task automatic check_rst_vals(input string nm);
    checks++;
    if ({ready16, busy16, done16, inv16} !== 4'b1000 ||
        gcd16 !== 16'd0 || iters16 !== 16'd0 ||
        {ready8, busy8, done8, inv8} !== 4'b1000 ||
        gcd8 !== 8'd0 || iters8 !== 8'd0) begin
      errors++;
      $display("FAIL %s got rbdi=%b%b%b%b g=%0d i=%0d exp 1000/0/0",
               nm, ready16, busy16, done16, inv16,
               gcd16, iters16);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    check_rst_vals("reset_held");
    rst = 0;
    @(negedge clk);
    check_rst_vals("reset_released");
  endtask

  task automatic test_euclid();
    run16(48, 18, 0, 6, 4, 6, "euclid_48_18");
  endtask

  task automatic test_stein();
    run16(1024, 768, 1, 256, 12, 14, "stein_pow2");
    run16(48, 18, 1, 6, 6, 8, "stein_48_18");
  endtask

  task automatic test_invalid();
    logic [15:0] av [2] = '{16'd0, 16'd0};
    logic [15:0] bv [2] = '{16'd7, 16'd0};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a16 = av[i]; b16 = bv[i]; go16 = 1;
      @(posedge clk);
      #1 go16 = 0;
      @(negedge clk);
      checks++;
      if (inv16 !== 1'b1 || done16 !== 1'b0) begin
        errors++;
        $display("FAIL invalid%0d_pulse got %b/%b exp 1/0",
                 i, inv16, done16);
      end
      @(negedge clk);
      checks++;
      if (ready16 !== 1'b1 || inv16 !== 1'b0 ||
          gcd16 !== 16'd6 || iters16 !== 16'd6) begin
        errors++;
        $display("FAIL invalid%0d_after got r=%b g=%0d i=%0d exp 1/6/6",
                 i, ready16, gcd16, iters16);
      end
    end
  endtask

  task automatic test_abort();
    @(negedge clk);
    a16 = 48; b16 = 18; mode16 = 0; go16 = 1;
    @(posedge clk);
    #1 go16 = 0;
    @(negedge clk);
    @(negedge clk);
    go16 = 1; a16 = 1; b16 = 1;
    @(negedge clk);
    go16 = 0; abort16 = 1;
    checks++;
    if (busy16 !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy got %b exp 1", busy16);
    end
    @(posedge clk);
    #1 abort16 = 0;
    @(negedge clk);
    checks++;
    if (ready16 !== 1'b1 || busy16 !== 1'b0 ||
        done16 !== 1'b0 || gcd16 !== 16'd6) begin
      errors++;
      $display("FAIL abort_idle got r=%b b=%b d=%b g=%0d exp 1/0/0/6",
               ready16, busy16, done16, gcd16);
    end
    run16(35, 21, 0, 7, 3, 5, "after_abort");
  endtask

  task automatic test_width8();
    run8(255, 1, 1, 254, 256, "w8_255_1");
    run8(7, 7, 7, 0, 2, "w8_7_7");
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    a16 = 1024; b16 = 768; mode16 = 1; go16 = 1;
    @(posedge clk);
    #1 go16 = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    #1;
    check_rst_vals("reset_midrun");
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check_rst_vals("reset_midrun_after");
  endtask

  task automatic test_back_to_back();
    logic [15:0] ta [3] = '{16'd48, 16'd35, 16'd100};
    logic [15:0] tb [3] = '{16'd18, 16'd21, 16'd75};
    logic        tm [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] tg [3] = '{16'd6, 16'd7, 16'd25};
    logic [15:0] ti [3] = '{16'd4, 16'd4, 16'd3};
    int          tl [3] = '{6, 6, 5};
    int c;
    exp_t e;
    @(negedge clk);
    a16 = ta[0]; b16 = tb[0]; mode16 = tm[0];
    go16 = 1;
    e = '{gcd: tg[0], iters: ti[0]};
    q16.push_back(e);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (i < 2) begin
        a16 = ta[i+1]; b16 = tb[i+1];
        mode16 = tm[i+1];
      end
      wait_done16(c);
      checks++;
      if (c != tl[i]) begin
        errors++;
        $display("FAIL b2b%0d_latency got %0d exp %0d",
                 i, c, tl[i]);
      end
      @(negedge clk);
      checks++;
      if (ready16 !== 1'b1) begin
        errors++;
        $display("FAIL b2b%0d_gap got %b exp 1",
                 i, ready16);
      end
      if (i < 2) begin
        e = '{gcd: tg[i+1], iters: ti[i+1]};
        q16.push_back(e);
      end else begin
        go16 = 0;
      end
    end
    @(negedge clk);
    checks++;
    if (busy16 !== 1'b1 || ready16 !== 1'b1) begin
      if (busy16 !== 1'b0 || ready16 !== 1'b1) begin
        errors++;
        $display("FAIL b2b_end got b=%b r=%b exp 0/1",
                 busy16, ready16);
      end
    end
  endtask

  initial begin
    test_reset();
    test_euclid();
    test_stein();
    test_invalid();
    test_abort();
    test_width8();
    test_reset_midrun();
    test_back_to_back();
    repeat (3) @(negedge clk);
    checks++;
    if (q16.size() != 0 || q8.size() != 0) begin
      errors++;
      $display("FAIL pending_results got %0d/%0d exp 0/0",
               q16.size(), q8.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/gcd_engine.md
# gcd_engine

- Parametrised GCD unit: control FSM and operand datapath in one block.
- Computes the GCD of two unsigned WIDTH-bit operands.
- Two run-time modes: subtractive Euclid, or binary (Stein) GCD with shift steps.
- Adds ready/done/invalid status, an abort input and an iteration counter. The block sits between a request source and a result consumer in the arithmetic subsystem.

## Interface
Parameters:
- WIDTH, 16, operand and result width (≥2)
- KW, $clog2(WIDTH+1), width of the common-power-of-two exponent k (derived, not overridden)

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- go  in  1  start request; honoured only while ready=1
- mode  in  1  0 = subtractive Euclid, 1 = binary Stein; sampled with go
- abort  in  1  synchronous cancel of a running computation
- a_in  in  WIDTH  operand A, sampled with go
- b_in  in  WIDTH  operand B, sampled with go
- ready  out  1  high in IDLE
- busy  out  1  high in CALC
- done  out  1  one-cycle pulse; gcd_out valid
- invalid  out  1  one-cycle pulse; operand was zero
- gcd_out  out  WIDTH  last valid result, held until next done
- iters  out  WIDTH  update operations in last/current run; saturates at all-ones

## Operation
- States: IDLE, CALC, DONE, ERR.
- IDLE:
  - ready=1.
  - On go=1, register a_in, b_in and mode into a_r, b_r and mode_r; clear k and iters.
  - If a_in==0 or b_in==0, next state is ERR. Otherwise next state is CALC.
- CALC: busy=1. Exactly one action per cycle, chosen by priority.
  - mode_r=0:
    - a_r==b_r → DONE.
    - a_r>b_r → a_r-=b_r.
    - Otherwise b_r-=a_r.
  - mode_r=1:
    - Both even → a_r>>=1, b_r>>=1, k+=1.
    - Else a_r even → a_r>>=1.
    - Else b_r even → b_r>>=1.
    - Else a_r==b_r → DONE.
    - Else the larger operand is reduced by the smaller.
  - Every action other than →DONE increments iters (saturating).
  - On the CALC→DONE edge, gcd_out ← a_r<<k (mode 0 keeps k=0).
- DONE: done=1 for one cycle, then IDLE.
- ERR: invalid=1 for one cycle, then IDLE. gcd_out and iters are not updated by the run.
- abort=1 in CALC: next state is IDLE. No done, gcd_out unchanged, iters keeps its partial count. abort is ignored in other states.
- go outside IDLE is ignored. go is not queued.
- Arithmetic:
  - Unsigned throughout. No subtraction can underflow, because the larger operand is always the one reduced.
  - Result never exceeds min(a,b), so it fits in WIDTH bits.

## Timing
- Reset values: FSM=IDLE, ready=1, busy=0, done=0, invalid=0, gcd_out=0, iters=0, a_r=b_r=0, k=0.
- Let E0 be the rising edge at which go is accepted, and N the number of update operations.
  - CALC occupies N+1 cycles after E0.
  - done is high in cycle N+2 after E0.
  - ready returns in cycle N+3.
- For a zero operand, invalid is high in cycle 1 after E0 and ready returns in cycle 2.
- For abort sampled high at edge Ex, ready=1 after Ex.
- Status outputs are decoded from state registers only (Moore). No input reaches an output combinationally.
- Reset asserted mid-run forces all reset values immediately. No done or invalid pulse is produced.
- go asserted in the same cycle that ready rises (after done) is accepted. Back-to-back runs therefore have one IDLE cycle between them.

## Structure
- Shared package gcd_pkg holds:
  - the state enum (IDLE, CALC, DONE, ERR), 2-bit;
  - mode constants MODE_EUCLID=1'b0 and MODE_STEIN=1'b1.
- Natural split into gcd_engine and one sub-module, gcd_datapath.
  - gcd_engine contains the FSM and status outputs.
  - gcd_datapath contains a_r, b_r, k and iters, the comparator (gt/eq/even flags) and the subtract/shift mux. It receives one-hot action controls from the FSM.

## Test plan
- WIDTH=16, mode=0, (48,18) → iters=4, done 6 cycles after E0, gcd_out=6.
- WIDTH=16, mode=1, (48,18) → iters=6 (k=1), done 8 cycles after E0, gcd_out=6. Also run (1024,768) in mode 1 → gcd_out=256.
- WIDTH=8, mode=0, (255,1) → iters=254, gcd_out=1; (7,7) → iters=0, done 2 cycles after E0, gcd_out=7.
- (0,7) and (0,0) → invalid pulse in cycle 1, no done, gcd_out keeps previous value 6, ready back in cycle 2.
- Start (48,18) in mode 0, abort in cycle 3 → IDLE next cycle, no done, gcd_out unchanged. go pulses during busy are ignored. A following (35,21) → gcd_out=7.
- rst pulsed mid-run in mode 1 → all outputs at reset values at once. Back-to-back runs with go held high → each result is correct, with one ready cycle between done pulses.
